// File: rtl/alu_seq.sv
// Registered ALU: single-cycle ops 0-12 plus iterative unsigned MUL/DIVU/REMU
// behind a start/busy/done handshake. Outputs always hold the last completed result.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       ALUctrl,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int CW = SHW + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] mul_sum;
  logic [WIDTH:0]   r_sh;
  logic             ge;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  function automatic logic [WIDTH-1:0] single_op(
    input logic [3:0]       ctl,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y,
    input logic [SHW-1:0]   sh
  );
    logic [WIDTH-1:0] r;
    r = '0;
    case (ctl)
      4'd0:    r = x + y;
      4'd1:    r = x - y;
      4'd2:    r = x & y;
      4'd3:    r = x | y;
      4'd4:    r = x << sh;
      4'd5:    r = x >> sh;
      4'd6:    r = WIDTH'(x < y);
      // Branch compares: 0 means "condition holds"
      4'd7:    r = WIDTH'(!(x == y));
      4'd8:    r = WIDTH'(!(x != y));
      4'd9:    r = WIDTH'(!(x > y));
      4'd10:   r = WIDTH'(!(x >= y));
      4'd11:   r = WIDTH'(!(x < y));
      4'd12:   r = WIDTH'(!(x <= y));
      default: r = '0;
    endcase
    return r;
  endfunction

  // Shift-add step: a_q is the shifted multiplicand, b_q the shifting multiplier
  assign mul_sum = acc_q + (b_q[0] ? a_q : '0);

  // Restoring division step: a_q shifts dividend bits out and quotient bits in
  assign r_sh     = {acc_q, a_q[WIDTH-1]};
  assign ge       = (r_sh >= {1'b0, b_q});
  assign rem_next = ge ? (r_sh[WIDTH-1:0] - b_q) : r_sh[WIDTH-1:0];
  assign quo_next = {a_q[WIDTH-2:0], ge};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    out_d   = out_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    res     = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (ALUctrl >= 4'd13) begin
            a_d     = in1;
            b_d     = in2;
            acc_d   = '0;
            op_d    = ALUctrl[1:0];
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            res    = single_op(ALUctrl, in1, in2, shamt);
            out_d  = res;
            zero_d = (res == '0);
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (op_q == 2'b01) begin
          acc_d = mul_sum;
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
          res   = mul_sum;
        end else begin
          acc_d = rem_next;
          a_d   = quo_next;
          res   = (op_q == 2'b10) ? quo_next : rem_next;
        end
        if (cnt_q == LAST) begin
          out_d   = res;
          zero_d  = (res == '0);
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      zero_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign zero = zero_q;
  assign busy = (state_q == RUN);
  assign done = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=32 and WIDTH=8: each accepted start
// pushes its expected result and completion cycle; done pops and compares.
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start32, zero32, busy32, done32;
  logic [3:0]  ctl32;
  logic [31:0] a32, b32, out32;
  logic [4:0]  sh32;

  logic        start8, zero8, busy8, done8;
  logic [3:0]  ctl8;
  logic [7:0]  a8, b8, out8;
  logic [2:0]  sh8;

  alu_seq #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(start32), .ALUctrl(ctl32), .in1(a32), .in2(b32),
    .shamt(sh32), .out(out32), .zero(zero32), .busy(busy32), .done(done32)
  );

  alu_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .ALUctrl(ctl8), .in1(a8), .in2(b8),
    .shamt(sh8), .out(out8), .zero(zero8), .busy(busy8), .done(done8)
  );

  typedef struct {
    logic [31:0] v;
    int          cyc;
  } exp_t;

  exp_t sb32[$];
  exp_t sb8[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input int sh);
    logic [31:0] r;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a << sh;
      4'd5:  r = a >> sh;
      4'd6:  r = (a < b) ? 32'd1 : 32'd0;
      4'd7:  r = (a == b) ? 32'd0 : 32'd1;
      4'd8:  r = (a != b) ? 32'd0 : 32'd1;
      4'd9:  r = (a > b) ? 32'd0 : 32'd1;
      4'd10: r = (a >= b) ? 32'd0 : 32'd1;
      4'd11: r = (a < b) ? 32'd0 : 32'd1;
      4'd12: r = (a <= b) ? 32'd0 : 32'd1;
      4'd13: r = a * b;
      4'd14: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (done32 === 1'b1) begin
      if (sb32.size() == 0) check("dut32 spurious done", sb32.size(), 1);
      else begin
        exp_t e;
        e = sb32.pop_front();
        check("dut32 out", out32, e.v);
        check("dut32 zero", zero32, (e.v == 0));
        check("dut32 latency", cyc, e.cyc);
      end
    end
    if (done8 === 1'b1) begin
      if (sb8.size() == 0) check("dut8 spurious done", sb8.size(), 1);
      else begin
        exp_t e;
        e = sb8.pop_front();
        check("dut8 out", {24'd0, out8}, e.v);
        check("dut8 zero", zero8, (e.v == 0));
        check("dut8 latency", cyc, e.cyc);
      end
    end
  end

  task automatic drive32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int sh, input logic [31:0] exp, input bit push);
    ctl32 = op; a32 = a; b32 = b; sh32 = sh[4:0]; start32 = 1'b1;
    if (push) sb32.push_back('{exp, cyc + 1 + ((op >= 4'd13) ? 32 : 0)});
    @(posedge clk);
    #1 start32 = 1'b0;
  endtask

  task automatic drive8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [31:0] exp);
    ctl8 = op; a8 = a; b8 = b; sh8 = 3'd0; start8 = 1'b1;
    sb8.push_back('{exp, cyc + 1 + ((op >= 4'd13) ? 8 : 0)});
    @(posedge clk);
    #1 start8 = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 200; k++) begin
      if (sb32.size() == 0 && sb8.size() == 0) break;
      @(negedge clk);
    end
    check("drain timeout", sb32.size() + sb8.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] ra, rb;
    int          rs;
    rst = 1'b1;
    start32 = 0; ctl32 = 0; a32 = 0; b32 = 0; sh32 = 0;
    start8 = 0;  ctl8 = 0;  a8 = 0;  b8 = 0;  sh8 = 0;
    repeat (2) @(negedge clk);
    check("reset out", out32, 0);
    check("reset zero", zero32, 1);
    check("reset busy", busy32, 0);
    check("reset done", done32, 0);
    check("reset out8", out8, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single-cycle sweep, back-to-back
    drive32(4'd0,  32'hFFFF_FFFF, 32'd1, 0,  32'h0, 1);
    drive32(4'd1,  32'd5, 32'd7, 0,          32'hFFFF_FFFE, 1);
    drive32(4'd4,  32'd1, 32'd0, 31,         32'h8000_0000, 1);
    drive32(4'd10, 32'd4, 32'd4, 0,          32'd0, 1);
    drive32(4'd8,  32'd4, 32'd4, 0,          32'd1, 1);
    drive32(4'd2,  32'h0000_F0F0, 32'h0000_FF00, 0, 32'h0000_F000, 1);
    drive32(4'd3,  32'h0000_F0F0, 32'h0000_0F0F, 0, 32'h0000_FFFF, 1);
    drive32(4'd5,  32'h8000_0000, 32'd0, 4,  32'h0800_0000, 1);
    drive32(4'd6,  32'd3, 32'd5, 0,          32'd1, 1);
    drive32(4'd7,  32'd3, 32'd5, 0,          32'd1, 1);
    drive32(4'd9,  32'd5, 32'd3, 0,          32'd0, 1);
    drive32(4'd11, 32'd5, 32'd3, 0,          32'd1, 1);
    drive32(4'd12, 32'd3, 32'd3, 0,          32'd0, 1);
    for (int i = 0; i < 16; i++) begin
      op = 4'($urandom_range(0, 12));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      rs = $urandom_range(0, 31);
      drive32(op, ra, rb, rs, model(op, ra, rb, rs), 1);
    end
    wait_drain();

    // MUL with busy profile
    drive32(4'd13, 32'h0001_0003, 32'h0000_0005, 0, 32'h0005_000F, 1);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      check("mul busy high", busy32, 1);
    end
    @(negedge clk);
    check("mul busy low", busy32, 0);
    wait_drain();

    drive32(4'd14, 32'd100, 32'd7, 0, 32'd14, 1);          wait_drain();
    drive32(4'd15, 32'd100, 32'd7, 0, 32'd2, 1);           wait_drain();
    drive32(4'd14, 32'hFFFF_FFFF, 32'd1, 0, 32'hFFFF_FFFF, 1); wait_drain();
    drive32(4'd14, 32'd123, 32'd0, 0, 32'hFFFF_FFFF, 1);   wait_drain();
    drive32(4'd15, 32'd123, 32'd0, 0, 32'd123, 1);         wait_drain();
    for (int i = 0; i < 4; i++) begin
      op = 4'($urandom_range(13, 15));
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
      drive32(op, ra, rb, 0, model(op, ra, rb, 0), 1);
      wait_drain();
    end

    // Start during a running DIVU is ignored
    drive32(4'd14, 32'd1000, 32'd10, 0, 32'd100, 1);
    repeat (3) @(negedge clk);
    drive32(4'd0, 32'd1, 32'd1, 0, 32'd2, 0);
    wait_drain();
    repeat (3) @(negedge clk);
    check("ignored start out", out32, 32'd100);

    // Reset in the middle of a MUL
    drive32(4'd13, 32'd7, 32'd9, 0, 32'd63, 1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    sb32.delete();
    #1;
    check("midop reset out", out32, 0);
    check("midop reset zero", zero32, 1);
    check("midop reset busy", busy32, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    drive32(4'd0, 32'd2, 32'd3, 0, 32'd5, 1);
    wait_drain();

    // WIDTH=8 instance
    drive8(4'd13, 8'd15, 8'd17, 32'h0000_00FF); wait_drain();
    drive8(4'd14, 8'd200, 8'd9, 32'd22);        wait_drain();
    drive8(4'd15, 8'd200, 8'd9, 32'd2);         wait_drain();
    drive8(4'd15, 8'd77, 8'd0, 32'd77);         wait_drain();
    drive8(4'd1, 8'd3, 8'd5, 32'h0000_00FE);    wait_drain();

    repeat (10) @(negedge clk);
    check("scoreboard empty", sb32.size() + sb8.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
